// File: rtl/ps2_pkg.sv
// PS/2 host transmit shared types: FSM state encoding, frame and command constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int DATA_BITS = 8;
    localparam int ACK_EDGE  = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one open-drain PS/2 line.
// Latency: 2 + FILTER_CYCLES cycles from pad change to filtered output change.
// Backpressure: none; pulses shorter than FILTER_CYCLES cycles are dropped.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic line_i,
    output logic line_o
);

    localparam int CNTW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FILTER_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CNTW-1:0] cnt_q;
    logic            filt_q;

    // Synchronize the pad, then only follow it once it has differed for FILTER_CYCLES cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Latency: INHIBIT_CYCLES plus 11 device clocks plus line-idle wait; bits change 2+FILTER_CYCLES+1 cycles after a pad fall.
// Backpressure: tx_ready only in IDLE; requests while busy are dropped. Optional PS2_TX_RETRY_EN resends up to twice.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]    PAR_EDGE  = 4'(DATA_BITS + 1);
    localparam logic [3:0]    LAST_EDGE = 4'(ACK_EDGE);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] timer_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          nack_q;
    logic          clk_prev_q;

    logic          clk_filt, data_filt;
    logic          fall, tmo_state, complete, timeout, fail, retry_ok;
    logic [2:0]    bit_idx;
    logic          frame_bit_n;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clock  (clock),
        .reset  (reset),
        .line_i (ps2_clk_in),
        .line_o (clk_filt)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clock  (clock),
        .reset  (reset),
        .line_i (ps2_data_in),
        .line_o (data_filt)
    );

    assign fall      = clk_prev_q & ~clk_filt;
    assign tmo_state = state_q inside {REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE};
    assign complete  = (state_q == WAIT_IDLE) && clk_filt && data_filt;
    // A fall or a clean finish in the same cycle beats the timeout
    assign timeout   = tmo_state && (timer_q == TMO_LAST) && !fall && !complete;
    assign fail      = timeout || (complete && nack_q);
    assign bit_idx   = bit_cnt_q[2:0] - 3'd1;
    assign busy      = (state_q != IDLE);
    assign tx_ready  = (state_q == IDLE);

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_q;
    assign retry_ok = (retry_q != 2'd2);

    // Count failed attempts on the current byte; cleared on success and when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_q <= 2'd0;
        end else if (state_q == IDLE || tx_done) begin
            retry_q <= 2'd0;
        end else if (fail && retry_ok) begin
            retry_q <= retry_q + 2'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each device clock fall moves the frame on by one bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tx_valid) state_d = INHIBIT;
            INHIBIT:   if (timer_q == INH_LAST) state_d = REQ;
            REQ:       if (fall) state_d = DATA;
            DATA:      if (fall && bit_cnt_q == LAST_DATA) state_d = PARITY;
            PARITY:    if (fall) state_d = STOP;
            STOP:      if (fall) state_d = ACK;
            ACK:       state_d = WAIT_IDLE;
            WAIT_IDLE: if (complete) state_d = (nack_q && retry_ok) ? INHIBIT : IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = retry_ok ? INHIBIT : IDLE;
        end
    end

    // Datapath: cycle timer, fall counter, latched byte/parity and ACK sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q    <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            nack_q     <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_filt;

            if (state_d != state_q && (state_d == INHIBIT || state_d == REQ)) begin
                timer_q <= '0;
            end else if (state_q == IDLE || (fall && tmo_state)) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end

            if (state_d == INHIBIT && state_q != INHIBIT) begin
                bit_cnt_q <= 4'd0;
            end else if (fall && state_q inside {REQ, DATA, PARITY, STOP}
                         && bit_cnt_q != LAST_EDGE) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if (state_q == IDLE && tx_valid) begin
                shift_q <= tx_data;
                par_q   <= ~^tx_data;
            end

            if (state_q == STOP && fall) begin
                nack_q <= data_filt;
            end
        end
    end

    // Line drive for the bit set up by the latest fall: data bits LSB first, then parity, then released stop
    always_comb begin
        frame_bit_n = 1'b0;
        if (bit_cnt_q == PAR_EDGE) begin
            frame_bit_n = ~par_q;
        end else if (bit_cnt_q != 4'd0 && bit_cnt_q <= LAST_DATA) begin
            frame_bit_n = ~shift_q[bit_idx];
        end
    end

    // Outputs: pad enables and completion pulses; a timeout releases both lines at once
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        case (state_q)
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (timer_q == INH_LAST);
            end
            REQ:                 ps2_data_oe = 1'b1;
            DATA, PARITY, STOP:  ps2_data_oe = frame_bit_n;
            WAIT_IDLE: begin
                tx_done  = complete && !nack_q;
                tx_error = complete && nack_q && !retry_ok;
            end
            default: ;
        endcase
        if (timeout) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            tx_error    = !retry_ok;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device plus event and frame scoreboards.
// Latency: device clock period 40 cycles, host inhibit 20 cycles.
// Backpressure: requests issued only when idle except the deliberate busy-time request.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_error;
    logic       dev_clk_low, dev_data_low;

    int checks = 0;
    int errors = 0;

    bit         exp_evt[$];    // 0 = tx_done, 1 = tx_error
    logic [10:0] exp_frame[$]; // bit0 = start, bits1-8 = data LSB first, bit9 = parity, bit10 = stop

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (20),
        .TIMEOUT_CYCLES (200),
        .FILTER_CYCLES  (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the next queued expectation
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && (tx_done || tx_error)) begin
                if (tx_done && tx_error) begin
                    check("done_and_error_together", {tx_done, tx_error}, 2'b10);
                end
                if (exp_evt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual done=%0d error=%0d expected none",
                             tx_done, tx_error);
                end else begin
                    check("event_kind", {31'd0, tx_error}, {31'd0, exp_evt.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    // Device model: serves one frame, optionally stopping with clock held low at abort_edge
    task automatic dev_serve(input bit nack, input int abort_edge, input bit glitch);
        int n;
        logic [10:0] got;
        got = '0;
        n = 0;
        while (!ps2_clk_oe && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!ps2_clk_oe) begin
            check("inhibit_seen", {31'd0, ps2_clk_oe}, 32'd1);
            return;
        end
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("inhibit_len", n, 32'd20);
        check("start_bit_drive", {31'd0, ps2_data_oe}, 32'd1);
        repeat (20) @(negedge clock);
        got[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == abort_edge) return;
            repeat (20) @(negedge clock);
            dev_clk_low = 1'b0;
            if (k == 11) begin
                dev_data_low = 1'b0;
                break;
            end
            got[k] = ps2_data_in;
            for (int c = 0; c < 20; c++) begin
                @(negedge clock);
                if (glitch && k == 3 && c == 5) dev_clk_low = 1'b1;
                if (glitch && k == 3 && c == 6) dev_clk_low = 1'b0;
                if (!nack && k == 10 && c == 10) dev_data_low = 1'b1;
            end
        end
        if (exp_frame.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h expected none", got);
        end else begin
            check("frame_bits", {21'd0, got}, {21'd0, exp_frame.pop_front()});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({name, "_ready"}, {31'd0, tx_ready}, 32'd1);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // 0xED with ACK
        exp_frame.push_back(11'h7DA);
        exp_evt.push_back(1'b0);
        send(CMD_SET_LEDS);
        dev_serve(1'b0, 0, 1'b0);
        wait_idle("set_leds");

        // 0x07 with a one-cycle clock glitch mid-frame: parity 0
        exp_frame.push_back(11'h40E);
        exp_evt.push_back(1'b0);
        send(8'h07);
        dev_serve(1'b0, 0, 1'b1);
        wait_idle("glitch_07");

        // 0x00: parity 1
        exp_frame.push_back(11'h600);
        exp_evt.push_back(1'b0);
        send(8'h00);
        dev_serve(1'b0, 0, 1'b0);
        wait_idle("zero");

        // 0xFF with NACK
`ifdef PS2_TX_RETRY_EN
        for (int i = 0; i < 3; i++) exp_frame.push_back(11'h7FE);
        exp_evt.push_back(1'b1);
        send(CMD_RESET);
        for (int i = 0; i < 3; i++) dev_serve(1'b1, 0, 1'b0);
`else
        exp_frame.push_back(11'h7FE);
        exp_evt.push_back(1'b1);
        send(CMD_RESET);
        dev_serve(1'b1, 0, 1'b0);
`endif
        wait_idle("nack");

        // Device stops clocking after edge 4 while data is driven low
        exp_evt.push_back(1'b1);
        send(8'h00);
        dev_serve(1'b0, 4, 1'b0);
`ifdef PS2_TX_RETRY_EN
        for (int k = 1; k <= 3000 && busy; k++) begin
            @(negedge clock);
            if (k == 20) dev_clk_low = 1'b0;
        end
        check("timeout_retry_done", {31'd0, busy}, 32'd0);
`else
        n = 0;
        for (int k = 1; k <= 400 && n == 0; k++) begin
            @(negedge clock);
            if (k == 20) dev_clk_low = 1'b0;
            if (k == 203) check("oe_before_timeout", {31'd0, ps2_data_oe}, 32'd1);
            if (tx_error) begin
                n = k;
                check("oe_at_timeout", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                check("busy_at_timeout", {31'd0, busy}, 32'd1);
            end
        end
        check("timeout_latency", n, 32'd204);
        @(negedge clock);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);
`endif
        wait_idle("timeout");

        // Reset during edge 6 while data is driven low
        send(8'h1F);
        dev_serve(1'b0, 6, 1'b0);
        repeat (10) @(negedge clock);
        check("data_oe_before_reset", {31'd0, ps2_data_oe}, 32'd1);
        #2;
        reset        = 1'b1;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        #1;
        check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        exp_frame.push_back(11'h7FE);
        exp_evt.push_back(1'b0);
        send(CMD_RESET);
        dev_serve(1'b0, 0, 1'b0);
        wait_idle("after_reset");

        // Request while busy must be dropped
        exp_frame.push_back(11'h7DA);
        exp_evt.push_back(1'b0);
        send(CMD_SET_LEDS);
        fork
            dev_serve(1'b0, 0, 1'b0);
            begin
                repeat (100) @(negedge clock);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clock);
                tx_valid = 1'b0;
            end
        join
        wait_idle("busy_req");
        repeat (50) @(negedge clock);
        check("no_second_frame", {31'd0, busy}, 32'd0);

        repeat (20) @(negedge clock);
        check("events_drained", exp_evt.size(), 32'd0);
        check("frames_drained", exp_frame.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the attached keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Counterpart of the existing PS/2 receive path (PS2_Interface); shares the same open-drain ps2_clock/ps2_data lines in skeleton.
- Runs in the `clock` domain; the top level drives the pads low when the *_oe outputs are high.
- `busy` lets the receive path ignore line activity during a host transmission.

Parameters:
- INHIBIT_CYCLES, 6000, cycles ps2 clock is held low before the start bit (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, max cycles between device clock falling edges, and for final idle, before abort (15 ms).
- FILTER_CYCLES, 4, cycles a synchronized input must stay stable before its filtered value changes.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send; captured when tx_valid && tx_ready.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw ps2 clock pad value (asynchronous).
- ps2_data_in  in  1  raw ps2 data pad value (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2 clock low.
- ps2_data_oe  out  1  1 = drive ps2 data low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse: frame acknowledged by the device.
- tx_error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset values (asserted asynchronously, effective immediately):
  - both *_oe = 0, so the lines are released even mid-frame.
  - tx_done = 0, tx_error = 0, busy = 0, state = IDLE, tx_ready = 1.
- Input conditioning:
  - each pad passes through a 2-FF synchronizer, then the filter.
  - fall = filtered clock was 1 the previous cycle and is 0 this cycle.
  - latency from pad edge to fall is 2 + FILTER_CYCLES cycles.
- IDLE:
  - tx_valid && tx_ready latches shift = tx_data.
  - latches par = ~^tx_data (odd parity).
  - clears bit counter and timer, goes to INHIBIT.
  - tx_valid while busy is ignored and has no side effects.
- INHIBIT:
  - clk_oe = 1, data_oe = 0 for INHIBIT_CYCLES cycles.
  - on the last cycle, data_oe = 1; next state REQ.
- REQ:
  - clk_oe = 0, data_oe = 1 (start bit), timer restarts.
- Each fall in REQ, DATA or PARITY sets up the next bit; edge k means the k-th fall since REQ:
  - edges 1-8: data_oe = ~shift[k-1] (LSB first; driving low sends 0).
  - edge 9: data_oe = ~par.
  - edge 10: data_oe = 0 (stop bit 1).
  - state sequence: REQ -> DATA -> PARITY -> STOP -> ACK.
- ACK:
  - on edge 11, sample filtered data: 0 = ACK, 1 = NACK.
  - then enter WAIT_IDLE.
- WAIT_IDLE:
  - wait until filtered clock and data are both 1.
  - then pulse tx_done (ACK) or tx_error (NACK), return to IDLE.
- Timeout:
  - the timer clears on every fall and counts in REQ through WAIT_IDLE.
  - reaching TIMEOUT_CYCLES-1 forces both oe = 0, pulses tx_error, enters IDLE the next cycle.
- Simultaneous timeout and fall: the fall wins.
- tx_done and tx_error are never high in the same cycle.
- Counter width = $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1); counters saturate and never wrap.
- Bit counter is 4 bits, range 0-11.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - on NACK or timeout, the latched byte is resent from INHIBIT, up to 2 retries.
  - tx_error pulses only after the third failure.
  - busy stays high between attempts.
  - a 2-bit retry counter clears on tx_done and in IDLE.
- Undefined: the first failure pulses tx_error; no retry logic is built.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE).
  - the frame constants: DATA_BITS=8, ACK_EDGE=11.
  - the command constants: CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF.
- Sub-module ps2_line_filter (synchronizer plus stability filter, one per line), instantiated twice.

Test Plan (bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, FILTER_CYCLES=2; device model period 40 cycles):
- Send 0xED, device ACKs:
  - clk_oe high for exactly 20 cycles.
  - bits sampled on device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - then exactly one tx_done pulse; tx_ready back to 1.
- Send 0x07:
  - parity bit sampled = 0.
  - send 0x00: parity bit sampled = 1.
- Device NACK (data high on edge 11) on 0xFF:
  - one tx_error pulse, no tx_done.
  - with PS2_TX_RETRY_EN: three full frames, then one tx_error.
- Device stops clocking after edge 4:
  - 200 cycles later both oe = 0, tx_error pulses, busy falls the next cycle.
- Assert reset during edge 6 with data_oe = 1:
  - both oe = 0 in the same cycle, tx_ready = 1, no tx_done or tx_error pulse.
  - next request transmits correctly.
- Pulse tx_valid with 0x55 while busy sending 0xED:
  - the second request is ignored; only 0xED appears on the line.
- 1-cycle glitch on ps2_clk_in:
  - no bit advance occurs.
